// File: rtl/model_ntm_vector_controller.sv
// Runs one shared scalar arithmetic core element by element over a vector of operand pairs.
// Optional watchdog on the scalar core: define MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN.
module model_ntm_vector_controller #(
  parameter int DATA_SIZE      = 64,
  parameter int CONTROL_SIZE   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] CONTROL_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_IN,
  output logic                    DATA_IN_REQUEST,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    SCALAR_START,
  input  logic                    SCALAR_READY,
  output logic [CONTROL_SIZE-1:0] SCALAR_CONTROL,
  output logic [DATA_SIZE-1:0]    SCALAR_DATA_A,
  output logic [DATA_SIZE-1:0]    SCALAR_DATA_B,
  input  logic [DATA_SIZE-1:0]    SCALAR_DATA_IN,
  output logic                    ERROR
);

  typedef enum logic [1:0] {STARTER, INPUT, OPERATION, ENDER} state_t;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  state_t                  state_q;
  logic [DATA_SIZE-1:0]    size_q;
  logic [DATA_SIZE-1:0]    index_q;
  logic [DATA_SIZE-1:0]    dataA_q;
  logic [DATA_SIZE-1:0]    dataB_q;
  logic [DATA_SIZE-1:0]    dataOut_q;
  logic [CONTROL_SIZE-1:0] control_q;
  logic                    haveA_q;
  logic                    haveB_q;
  logic                    ready_q;
  logic                    dataInRequest_q;
  logic                    dataOutEnable_q;
  logic                    scalarStart_q;

  logic haveA_d;
  logic haveB_d;
  logic lastElement;
  logic scalarAccept;

  assign haveA_d      = haveA_q | DATA_A_IN_ENABLE;
  assign haveB_d      = haveB_q | DATA_B_IN_ENABLE;
  assign lastElement  = (index_q == (size_q - ONE));
  // The core cannot legitimately answer in the same cycle it is started.
  assign scalarAccept = SCALAR_READY & ~scalarStart_q;

`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic          error_q;

  assign ERROR = error_q;
`else
  logic unusedTimeout;

  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign ERROR         = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= STARTER;
      size_q          <= '0;
      index_q         <= '0;
      dataA_q         <= '0;
      dataB_q         <= '0;
      dataOut_q       <= '0;
      control_q       <= '0;
      haveA_q         <= 1'b0;
      haveB_q         <= 1'b0;
      ready_q         <= 1'b0;
      dataInRequest_q <= 1'b0;
      dataOutEnable_q <= 1'b0;
      scalarStart_q   <= 1'b0;
`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
      timer_q         <= '0;
      error_q         <= 1'b0;
`endif
    end else begin
      ready_q         <= 1'b0;
      dataInRequest_q <= 1'b0;
      dataOutEnable_q <= 1'b0;
      scalarStart_q   <= 1'b0;
      case (state_q)
        STARTER: begin
          if (START) begin
            size_q    <= SIZE_IN;
            control_q <= CONTROL_IN;
            index_q   <= '0;
            haveA_q   <= 1'b0;
            haveB_q   <= 1'b0;
`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
            if (SIZE_IN == '0) begin
              ready_q <= 1'b1;
            end else begin
              dataInRequest_q <= 1'b1;
              state_q         <= INPUT;
            end
          end
        end
        INPUT: begin
          if (DATA_A_IN_ENABLE) dataA_q <= DATA_A_IN;
          if (DATA_B_IN_ENABLE) dataB_q <= DATA_B_IN;
          if (haveA_d && haveB_d) begin
            scalarStart_q <= 1'b1;
            haveA_q       <= 1'b0;
            haveB_q       <= 1'b0;
            state_q       <= OPERATION;
`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
            timer_q       <= '0;
`endif
          end else begin
            haveA_q <= haveA_d;
            haveB_q <= haveB_d;
          end
        end
        OPERATION: begin
          if (scalarAccept) begin
            dataOut_q <= SCALAR_DATA_IN;
            state_q   <= ENDER;
          end
`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
          // A hung core aborts the whole vector; the element result is dropped.
          else if (timer_q == TIMEOUT_LAST) begin
            error_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= STARTER;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        ENDER: begin
          dataOutEnable_q <= 1'b1;
          if (lastElement) begin
            ready_q <= 1'b1;
            state_q <= STARTER;
          end else begin
            index_q         <= index_q + ONE;
            dataInRequest_q <= 1'b1;
            state_q         <= INPUT;
          end
        end
        default: state_q <= STARTER;
      endcase
    end
  end

  assign READY           = ready_q;
  assign DATA_IN_REQUEST = dataInRequest_q;
  assign DATA_OUT_ENABLE = dataOutEnable_q;
  assign DATA_OUT        = dataOut_q;
  assign SCALAR_START    = scalarStart_q;
  assign SCALAR_CONTROL  = control_q;
  assign SCALAR_DATA_A   = dataA_q;
  assign SCALAR_DATA_B   = dataB_q;

endmodule

// File: tb/tb_model_ntm_vector_controller.sv
// Directed bench for model_ntm_vector_controller with a behavioural A+B scalar core.
// Also covers the watchdog when MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN is defined.
module tb_model_ntm_vector_controller;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY;
  logic [CW-1:0] CONTROL_IN = '0;
  logic [DW-1:0] SIZE_IN = '0;
  logic          DATA_IN_REQUEST;
  logic          DATA_A_IN_ENABLE = 1'b0;
  logic          DATA_B_IN_ENABLE = 1'b0;
  logic [DW-1:0] DATA_A_IN = '0;
  logic [DW-1:0] DATA_B_IN = '0;
  logic          DATA_OUT_ENABLE;
  logic [DW-1:0] DATA_OUT;
  logic          SCALAR_START;
  logic          SCALAR_READY;
  logic [CW-1:0] SCALAR_CONTROL;
  logic [DW-1:0] SCALAR_DATA_A;
  logic [DW-1:0] SCALAR_DATA_B;
  logic [DW-1:0] SCALAR_DATA_IN;
  logic          ERROR;

  model_ntm_vector_controller #(
    .DATA_SIZE(DW), .CONTROL_SIZE(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .CONTROL_IN(CONTROL_IN), .SIZE_IN(SIZE_IN),
    .DATA_IN_REQUEST(DATA_IN_REQUEST),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT),
    .SCALAR_START(SCALAR_START), .SCALAR_READY(SCALAR_READY),
    .SCALAR_CONTROL(SCALAR_CONTROL), .SCALAR_DATA_A(SCALAR_DATA_A),
    .SCALAR_DATA_B(SCALAR_DATA_B), .SCALAR_DATA_IN(SCALAR_DATA_IN),
    .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int cycleNo = 0;
  always @(posedge CLK) cycleNo++;

  int vectors = 0;
  int miscompares = 0;

  // Event log filled by the monitor at negedge, cleared between scenarios.
  int            doeCount, readyCount, readyWithDoe, dirWithDoe, reqCount, startCount;
  int            readyCycle;
  logic [DW-1:0] resultArr[16];
  int            doeCycArr[16];
  logic [DW-1:0] scalarAArr[16];
  logic [DW-1:0] scalarBArr[16];
  logic [CW-1:0] ctrlArr[16];
  int            startCycArr[16];
  int            pairCyc[16];
  int            pairCount;

  bit scalarOn = 1'b1;
  int lat = 4;

  task automatic clearCounts();
    doeCount = 0; readyCount = 0; readyWithDoe = 0; dirWithDoe = 0;
    reqCount = 0; startCount = 0; readyCycle = -1; pairCount = 0;
    for (int i = 0; i < 16; i++) begin
      resultArr[i] = 'x; scalarAArr[i] = 'x; scalarBArr[i] = 'x; ctrlArr[i] = 'x;
      doeCycArr[i] = -1000; startCycArr[i] = -1000; pairCyc[i] = -1000;
    end
  endtask

  initial begin
    clearCounts();
    forever begin
      @(negedge CLK);
      if (RST === 1'b0) begin
        if (DATA_OUT_ENABLE === 1'b1) begin
          if (doeCount < 16) begin
            resultArr[doeCount] = DATA_OUT;
            doeCycArr[doeCount] = cycleNo;
          end
          doeCount++;
          if (DATA_IN_REQUEST === 1'b1) dirWithDoe++;
          if (READY === 1'b1) readyWithDoe++;
        end
        if (READY === 1'b1) begin
          readyCount++;
          readyCycle = cycleNo;
        end
        if (SCALAR_START === 1'b1) begin
          if (startCount < 16) begin
            scalarAArr[startCount]  = SCALAR_DATA_A;
            scalarBArr[startCount]  = SCALAR_DATA_B;
            ctrlArr[startCount]     = SCALAR_CONTROL;
            startCycArr[startCount] = cycleNo;
          end
          startCount++;
        end
        if (DATA_IN_REQUEST === 1'b1) reqCount++;
      end
    end
  end

  // Scalar core model: answers A+B exactly lat cycles after the SCALAR_START cycle.
  initial begin
    logic [DW-1:0] a, b;
    SCALAR_READY   = 1'b0;
    SCALAR_DATA_IN = '0;
    forever begin
      @(posedge CLK); #1;
      SCALAR_READY = 1'b0;
      if (SCALAR_START === 1'b1 && scalarOn && RST === 1'b0) begin
        a = SCALAR_DATA_A;
        b = SCALAR_DATA_B;
        repeat (lat) begin @(posedge CLK); #1; end
        SCALAR_READY   = 1'b1;
        SCALAR_DATA_IN = a + b;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] size, input logic [CW-1:0] ctrl);
    START = 1'b1; SIZE_IN = size; CONTROL_IN = ctrl;
    tick();
    START = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (DATA_IN_REQUEST !== 1'b1 && n < 100) begin tick(); n++; end
    checkOutput({tag, " request"}, DATA_IN_REQUEST, 1);
  endtask

  task automatic doPair(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    waitReq(tag);
    DATA_A_IN = a; DATA_B_IN = b;
    DATA_A_IN_ENABLE = 1'b1; DATA_B_IN_ENABLE = 1'b1;
    if (pairCount < 16) pairCyc[pairCount] = cycleNo;
    pairCount++;
    tick();
    DATA_A_IN_ENABLE = 1'b0; DATA_B_IN_ENABLE = 1'b0;
  endtask

  task automatic waitReady(input string tag, input int target);
    int n = 0;
    while (readyCount < target && n < 300) begin tick(); n++; end
    checkOutput({tag, " ready count"}, readyCount, target);
  endtask

  initial begin
    // Power-on reset state
    repeat (3) tick();
    checkOutput("rst READY", READY, 0);
    checkOutput("rst DATA_IN_REQUEST", DATA_IN_REQUEST, 0);
    checkOutput("rst DATA_OUT_ENABLE", DATA_OUT_ENABLE, 0);
    checkOutput("rst SCALAR_START", SCALAR_START, 0);
    checkOutput("rst DATA_OUT", DATA_OUT, 0);
    checkOutput("rst SCALAR_CONTROL", SCALAR_CONTROL, 0);
    checkOutput("rst SCALAR_DATA_A", SCALAR_DATA_A, 0);
    checkOutput("rst SCALAR_DATA_B", SCALAR_DATA_B, 0);
    checkOutput("rst ERROR", ERROR, 0);
    RST = 1'b0;
    tick();

    // Reset in the middle of INPUT with operand A already latched
    applyStimulus(2, 1);
    waitReq("midrst");
    DATA_A_IN = 5; DATA_A_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    tick();
    checkOutput("midrst A latched", SCALAR_DATA_A, 5);
    #2 RST = 1'b1;
    #1;
    checkOutput("midrst async SCALAR_DATA_A", SCALAR_DATA_A, 0);
    checkOutput("midrst async SCALAR_CONTROL", SCALAR_CONTROL, 0);
    checkOutput("midrst async DATA_IN_REQUEST", DATA_IN_REQUEST, 0);
    tick(); tick();
    RST = 1'b0;
    clearCounts();
    repeat (4) tick();
    checkOutput("midrst no READY", readyCount, 0);
    applyStimulus(2, 1);
    waitReq("midrst B only");
    DATA_B_IN = 7; DATA_B_IN_ENABLE = 1'b1;
    tick();
    DATA_B_IN_ENABLE = 1'b0;
    repeat (3) tick();
    checkOutput("midrst A flag cleared", startCount, 0);
    DATA_A_IN = 3; DATA_A_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    doPair("midrst p2", 1, 1);
    waitReady("midrst", 1);
    checkOutput("midrst DOE count", doeCount, 2);
    checkOutput("midrst result0", resultArr[0], 10);
    checkOutput("midrst result1", resultArr[1], 2);

    // Zero-length vector
    clearCounts();
    applyStimulus(0, 5);
    checkOutput("size0 READY next cycle", READY, 1);
    tick();
    checkOutput("size0 READY single", READY, 0);
    repeat (3) tick();
    checkOutput("size0 requests", reqCount, 0);
    checkOutput("size0 scalar starts", startCount, 0);
    checkOutput("size0 DOE", doeCount, 0);
    checkOutput("size0 ready count", readyCount, 1);

    // Three-element add; SIZE_IN/CONTROL_IN disturbed after START
    clearCounts();
    lat = 4;
    applyStimulus(3, 2);
    SIZE_IN = 7; CONTROL_IN = 9;
    doPair("add p0", 1, 2);
    doPair("add p1", 3, 4);
    doPair("add p2", 5, 6);
    waitReady("add", 1);
    repeat (3) tick();
    checkOutput("add DOE count", doeCount, 3);
    checkOutput("add result0", resultArr[0], 3);
    checkOutput("add result1", resultArr[1], 7);
    checkOutput("add result2", resultArr[2], 11);
    checkOutput("add ctrl0", ctrlArr[0], 2);
    checkOutput("add ctrl1", ctrlArr[1], 2);
    checkOutput("add ctrl2", ctrlArr[2], 2);
    checkOutput("add READY with last DOE", readyWithDoe, 1);
    checkOutput("add REQ with DOE", dirWithDoe, 2);
    checkOutput("add latency", doeCycArr[0] - pairCyc[0], 3 + lat);
    checkOutput("add DATA_OUT held", DATA_OUT, 11);
    checkOutput("add ready count", readyCount, 1);

    // Operand arrival orders
    clearCounts();
    applyStimulus(3, 0);
    waitReq("order p0");
    DATA_B_IN = 20; DATA_B_IN_ENABLE = 1'b1;
    tick();
    DATA_B_IN_ENABLE = 1'b0;
    tick();
    DATA_A_IN = 1; DATA_A_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    doPair("order p1", 2, 3);
    waitReq("order p2");
    DATA_A_IN = 9; DATA_A_IN_ENABLE = 1'b1;
    tick();
    DATA_A_IN = 10;
    tick();
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN = 4; DATA_B_IN_ENABLE = 1'b1;
    tick();
    DATA_B_IN_ENABLE = 1'b0;
    waitReady("order", 1);
    checkOutput("order scalar starts", startCount, 3);
    checkOutput("order p2 SCALAR_DATA_A", scalarAArr[2], 10);
    checkOutput("order p2 SCALAR_DATA_B", scalarBArr[2], 4);
    checkOutput("order result0", resultArr[0], 21);
    checkOutput("order result1", resultArr[1], 5);
    checkOutput("order result2", resultArr[2], 14);

    // Inputs pulsed while the scalar core is busy
    clearCounts();
    lat = 6;
    applyStimulus(2, 3);
    doPair("ignore p0", 4, 5);
    tick();
    START = 1'b1; SIZE_IN = 5; CONTROL_IN = 7;
    DATA_A_IN = 100; DATA_B_IN = 200;
    DATA_A_IN_ENABLE = 1'b1; DATA_B_IN_ENABLE = 1'b1;
    tick();
    START = 1'b0; DATA_A_IN_ENABLE = 1'b0; DATA_B_IN_ENABLE = 1'b0;
    checkOutput("ignore SCALAR_DATA_A", SCALAR_DATA_A, 4);
    checkOutput("ignore SCALAR_DATA_B", SCALAR_DATA_B, 5);
    checkOutput("ignore SCALAR_CONTROL", SCALAR_CONTROL, 3);
    doPair("ignore p1", 6, 7);
    waitReady("ignore", 1);
    repeat (4) tick();
    checkOutput("ignore DOE count", doeCount, 2);
    checkOutput("ignore result0", resultArr[0], 9);
    checkOutput("ignore result1", resultArr[1], 13);
    checkOutput("ignore scalar starts", startCount, 2);
    checkOutput("ignore requests", reqCount, 2);
    checkOutput("ignore ready count", readyCount, 1);
    lat = 4;

`ifdef MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN
    // Hung scalar core trips the watchdog
    clearCounts();
    scalarOn = 1'b0;
    applyStimulus(2, 1);
    doPair("timeout p0", 8, 8);
    waitReady("timeout", 1);
    checkOutput("timeout ERROR", ERROR, 1);
    checkOutput("timeout READY delay", readyCycle - startCycArr[0], TO);
    checkOutput("timeout no DOE", doeCount, 0);
    repeat (3) tick();
    checkOutput("timeout ERROR sticky", ERROR, 1);
    scalarOn = 1'b1;
    applyStimulus(0, 0);
    checkOutput("timeout ERROR cleared", ERROR, 0);
    checkOutput("timeout restart READY", READY, 1);
`else
    // Without the watchdog a silent core stalls the vector until reset
    clearCounts();
    scalarOn = 1'b0;
    applyStimulus(1, 1);
    doPair("stall p0", 8, 8);
    repeat (40) tick();
    checkOutput("stall no READY", readyCount, 0);
    checkOutput("stall no DOE", doeCount, 0);
    checkOutput("stall ERROR", ERROR, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    scalarOn = 1'b1;
    tick();
`endif

    clearCounts();
    applyStimulus(1, 6);
    doPair("final p0", 30, 12);
    waitReady("final", 1);
    checkOutput("final result", resultArr[0], 42);
    checkOutput("final ERROR", ERROR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/model_ntm_vector_controller.md
Name: model_ntm_vector_controller

Overview:
- Sequences one external scalar operator (adder/multiplier FSM core) over a vector of SIZE_IN element pairs: accepts element pairs, issues one scalar operation per pair, streams results out, then reports completion.
- Sits between vector-level NTM blocks (controller, addressing, read/write heads) and the shared scalar arithmetic cores.
- Data words are opaque DATA_SIZE-bit vectors (real encoding owned by the scalar core).
- The scalar operation is selected per vector by CONTROL_IN and forwarded unchanged.

Parameters:
DATA_SIZE, 64, width of data words, SIZE_IN and the element index
CONTROL_SIZE, 4, width of the operation-select field
TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
START  in  1  one-cycle pulse, begins a vector operation
READY  out  1  one-cycle pulse, vector operation complete
CONTROL_IN  in  CONTROL_SIZE  scalar operation select, sampled on START
SIZE_IN  in  DATA_SIZE  element count, sampled on START
DATA_IN_REQUEST  out  1  one-cycle pulse, block ready for next element pair
DATA_A_IN_ENABLE  in  1  DATA_A_IN valid strobe
DATA_B_IN_ENABLE  in  1  DATA_B_IN valid strobe
DATA_A_IN  in  DATA_SIZE  operand A element
DATA_B_IN  in  DATA_SIZE  operand B element
DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT valid
DATA_OUT  out  DATA_SIZE  result element, held until the next result
SCALAR_START  out  1  one-cycle pulse to the scalar core
SCALAR_READY  in  1  scalar core completion pulse
SCALAR_CONTROL  out  CONTROL_SIZE  latched CONTROL_IN
SCALAR_DATA_A  out  DATA_SIZE  latched operand A
SCALAR_DATA_B  out  DATA_SIZE  latched operand B
SCALAR_DATA_IN  in  DATA_SIZE  scalar core result
ERROR  out  1  watchdog flag (optional feature)

Behaviour:
- Reset, asynchronous and valid mid-operation: all outputs 0, index 0, A/B-received flags cleared, state STARTER. No partial READY is emitted after reset.
- STARTER: on START, latch SIZE_IN and CONTROL_IN and clear the index.
  - SIZE_IN=0: READY pulses on the next cycle; no DATA_IN_REQUEST, SCALAR_START or DATA_OUT_ENABLE; return to STARTER.
  - Otherwise: DATA_IN_REQUEST pulses on the next cycle; go to INPUT.
- INPUT: A and B are latched independently on their enables, in any order or in the same cycle. A repeated enable before the pair completes overwrites the latched value.
  - The cycle after both flags are set: SCALAR_START=1 for one cycle with SCALAR_DATA_A/B stable; flags cleared; go to OPERATION.
- OPERATION: wait for SCALAR_READY; SCALAR_READY is ignored in the SCALAR_START cycle itself.
  - On SCALAR_READY, latch SCALAR_DATA_IN to DATA_OUT and pulse DATA_OUT_ENABLE the next cycle; go to ENDER.
- ENDER:
  - If index == SIZE_latched-1: READY pulses in the same cycle as the last DATA_OUT_ENABLE; go to STARTER.
  - Otherwise: increment the index; DATA_IN_REQUEST pulses in the same cycle as DATA_OUT_ENABLE; go to INPUT.
- Minimum per-element latency: 3 cycles from pair complete to DATA_OUT_ENABLE, plus the scalar core latency.
- Ignored inputs:
  - START while not in STARTER.
  - DATA_*_ENABLE outside INPUT.
  - SCALAR_READY outside OPERATION.
- SIZE_IN and CONTROL_IN changes after START have no effect.
- The index counter is DATA_SIZE bits and never wraps, since SIZE_IN bounds it.

Optional Feature:
- Macro: MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in OPERATION.
  - If SCALAR_READY has not arrived after TIMEOUT_CYCLES cycles: ERROR=1 sticky, READY pulses once, DATA_OUT_ENABLE is not pulsed for that element, and the state returns to STARTER.
  - ERROR clears on the next accepted START or on RST.
- Disabled: no counter; ERROR tied 0; OPERATION waits indefinitely.

Test Plan:
- RST high mid-INPUT with A latched -> all outputs 0; after release, START with SIZE_IN=2 gives exactly 2 DATA_OUT_ENABLE pulses.
- START, SIZE_IN=0 -> READY 1 cycle later; no SCALAR_START, DATA_IN_REQUEST or DATA_OUT_ENABLE.
- SIZE_IN=3, CONTROL_IN=2, pairs (1,2),(3,4),(5,6), scalar model returns A+B after 4 cycles:
  - DATA_OUT sequence 3,7,11.
  - SCALAR_CONTROL=2 throughout.
  - READY coincides with the third DATA_OUT_ENABLE.
- Pair ordering: B before A, then same-cycle A+B, then A twice (values 9 then 10) before B -> single SCALAR_START per pair; SCALAR_DATA_A=10 for the third pair.
- START, SIZE_IN and DATA enables pulsed during OPERATION -> ignored; element count and results are unchanged.
- With MODEL_NTM_VECTOR_CONTROLLER_TIMEOUT_EN, TIMEOUT_CYCLES=8, scalar never responds -> ERROR=1 and READY after 8 OPERATION cycles; the next START clears ERROR.
